// File: rtl/icache_lined.sv
// Direct-mapped instruction cache with multi-word lines, refilled critical-word-first
// with wrap-around; lookup result registered, refill sequenced by a small FSM.
module icache_lined #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int INDEX_W         = 7,
  parameter int LINE_WORDS_LOG2 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_data_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_busy_i,
  input  logic              mem_valid_i,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam int TAG_W = ADDR_W - 2 - LINE_WORDS_LOG2 - INDEX_W;
  localparam int WCW   = (LINE_WORDS_LOG2 > 0) ? LINE_WORDS_LOG2 : 1;
  localparam int DA_W  = INDEX_W + LINE_WORDS_LOG2;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << DA_W;
  localparam logic [WCW-1:0] LAST_CNT = WCW'((1 << LINE_WORDS_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

  state_t              state;
  logic [TAG_W-1:0]    reqTag;
  logic [INDEX_W-1:0]  reqIndex;
  logic [WCW-1:0]      reqWord;
  logic [WCW-1:0]      wcnt;
  logic [WCW-1:0]      wordsDone;
  logic                memReq;
  logic [ADDR_W-1:0]   memAddr;
  logic                ifValid;
  logic [DATA_W-1:0]   ifData;
  logic [LINES-1:0]    validBits;

  logic [TAG_W-1:0]    tagMem  [LINES];
  logic [DATA_W-1:0]   dataMem [WORDS];

  logic [TAG_W-1:0]    lkTag;
  logic [INDEX_W-1:0]  lkIndex;
  logic [WCW-1:0]      lkWord;
  logic                hit;
  logic [DATA_W-1:0]   hitData;
  logic                fillWe;
  logic                tagWe;
  logic [WCW-1:0]      nextWord;
  logic                unusedByteBits;

  // With single-word lines the word field is empty; the 1-bit counter is then shifted out.
  function automatic logic [DA_W-1:0] dataAddr(input logic [INDEX_W-1:0] idx,
                                               input logic [WCW-1:0] w);
    return DA_W'({idx, w} >> (WCW - LINE_WORDS_LOG2));
  endfunction

  function automatic logic [ADDR_W-1:0] fillAddr(input logic [TAG_W-1:0] t,
                                                 input logic [INDEX_W-1:0] idx,
                                                 input logic [WCW-1:0] w);
    logic [ADDR_W-3:0] wordAddr;
    wordAddr = (ADDR_W-2)'({t, idx, w} >> (WCW - LINE_WORDS_LOG2));
    return {wordAddr, 2'b00};
  endfunction

  generate
    if (LINE_WORDS_LOG2 > 0) begin : gWordField
      assign lkWord = if_addr_i[2 +: WCW];
    end else begin : gNoWordField
      assign lkWord = '0;
    end
  endgenerate

  assign lkTag          = if_addr_i[ADDR_W-1 -: TAG_W];
  assign lkIndex        = if_addr_i[2 + LINE_WORDS_LOG2 +: INDEX_W];
  assign unusedByteBits = ^if_addr_i[1:0];
  assign hit            = validBits[lkIndex] && (tagMem[lkIndex] == lkTag);
  assign hitData        = dataMem[dataAddr(lkIndex, lkWord)];
  assign nextWord       = wcnt + WCW'(1);

  assign fillWe = rdy && !rst && !clr_i && (state == REFILL) && mem_valid_i && memReq;
  assign tagWe  = fillWe && (wordsDone == LAST_CNT);

  // Arrays carry no reset; the valid bits alone decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (fillWe) dataMem[dataAddr(reqIndex, wcnt)] <= mem_data_i;
    if (tagWe)  tagMem[reqIndex] <= reqTag;
  end

  // Refill responses are only taken while a request is actually presented, so a
  // stray pulse during the one-cycle request gap cannot advance the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      reqTag    <= '0;
      reqIndex  <= '0;
      reqWord   <= '0;
      wcnt      <= '0;
      wordsDone <= '0;
      memReq    <= 1'b0;
      memAddr   <= '0;
      ifValid   <= 1'b0;
      ifData    <= '0;
      validBits <= '0;
    end else if (rdy) begin
      ifValid <= 1'b0;
      if (clr_i) begin
        validBits <= '0;
        state     <= IDLE;
        memReq    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (if_req_i) begin
              reqTag   <= lkTag;
              reqIndex <= lkIndex;
              reqWord  <= lkWord;
              if (hit) begin
                ifValid <= 1'b1;
                ifData  <= hitData;
              end else begin
                state     <= REFILL;
                wcnt      <= lkWord;
                wordsDone <= '0;
                memReq    <= !mem_busy_i;
                memAddr   <= fillAddr(lkTag, lkIndex, lkWord);
              end
            end
          end
          REFILL: begin
            if (mem_valid_i && memReq) begin
              memReq <= 1'b0;
              if (wcnt == reqWord) ifData <= mem_data_i;
              if (wordsDone == LAST_CNT) begin
                validBits[reqIndex] <= 1'b1;
                state               <= RESP;
              end else begin
                wcnt      <= nextWord;
                wordsDone <= wordsDone + WCW'(1);
                memAddr   <= fillAddr(reqTag, reqIndex, nextWord);
              end
            end else begin
              memReq <= !mem_busy_i;
            end
          end
          RESP: begin
            ifValid <= 1'b1;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign if_ready_o = (state == IDLE);
  assign if_valid_o = ifValid;
  assign if_data_o  = ifData;
  assign mem_req_o  = memReq;
  assign mem_addr_o = memAddr;

endmodule
